// File: rtl/multi_debounce_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_debounce_if
// Brief    : Button bundle between raw button levels and the debouncer outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface multi_debounce_if #(
  parameter int N_CH = 5
) ();
  logic [N_CH-1:0] Btn;
  logic [N_CH-1:0] Btn_pulse;
  logic [N_CH-1:0] Btn_level;
  logic            Btn_any;

  modport master (
    output Btn,
    input  Btn_pulse,
    input  Btn_level,
    input  Btn_any
  );

  modport slave (
    input  Btn,
    output Btn_pulse,
    output Btn_level,
    output Btn_any
  );
endinterface
`default_nettype wire

// File: rtl/multi_debounce.sv
`default_nettype none
// ============================================================================
// Module   : multi_debounce
// Brief    : N-channel button debouncer with press pulse, held level and
//            optional auto-repeat pulses; channels are fully independent.
// Revision : 1.0 - initial release
// ============================================================================
module multi_debounce #(
  parameter int N_CH         = 5,
  parameter int CNT_W        = 14,
  parameter int SETTLE       = 6100,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 12200,
  parameter int REPEAT_RATE  = 2440
) (
  input  logic            CLK,
  input  logic            RESET_N,
  multi_debounce_if.slave bus
);

  localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] c_delay_last  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] c_rate_last   = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } state_t;

  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_s_btn;
  logic [N_CH-1:0] w_pulse_nxt;
  logic [N_CH-1:0] w_level_nxt;
  logic [N_CH-1:0] r_pulse;
  logic [N_CH-1:0] r_level;
  logic            r_any;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1 <= '0;
      r_s_btn <= '0;
    end else begin
      r_sync1 <= bus.Btn;
      r_s_btn <= r_sync1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           r_state;
    state_t           w_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_rpt_last;
    logic             r_rpt;
    logic             w_rpt;
    logic             w_pulse;
    logic             w_level;

    // First repeat waits the long delay, later ones the shorter rate.
    assign w_rpt_last = r_rpt ? c_rate_last : c_delay_last;

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_rpt   <= 1'b0;
      end else begin
        r_state <= w_state;
        r_cnt   <= w_cnt;
        r_rpt   <= w_rpt;
      end
    end

    always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_rpt   = r_rpt;
      w_pulse = 1'b0;
      w_level = r_level[i];
      case (r_state)
        IDLE: begin
          w_cnt = '0;
          w_rpt = 1'b0;
          if (r_s_btn[i]) begin
            w_state = PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (!r_s_btn[i]) begin
            w_state = IDLE;
            w_cnt   = '0;
          end else if (r_cnt == c_settle_last) begin
            w_state = HELD;
            w_cnt   = '0;
            w_pulse = 1'b1;
            w_level = 1'b1;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!r_s_btn[i]) begin
            w_state = REL_WAIT;
            w_cnt   = '0;
          end else if (REPEAT_EN == 0) begin
            w_cnt = '0;
          end else if (r_cnt == w_rpt_last) begin
            w_cnt   = '0;
            w_rpt   = 1'b1;
            w_pulse = 1'b1;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
        REL_WAIT: begin
          // A bounce back high resumes the hold; the repeat phase is kept.
          if (r_s_btn[i]) begin
            w_state = HELD;
            w_cnt   = '0;
          end else if (r_cnt == c_settle_last) begin
            w_state = IDLE;
            w_cnt   = '0;
            w_level = 1'b0;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state = IDLE;
          w_cnt   = '0;
        end
      endcase
    end

    assign w_pulse_nxt[i] = w_pulse;
    assign w_level_nxt[i] = w_level;
  end

  // Any-flag is built from next-state levels so it lines up with Btn_level.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pulse <= '0;
      r_level <= '0;
      r_any   <= 1'b0;
    end else begin
      r_pulse <= w_pulse_nxt;
      r_level <= w_level_nxt;
      r_any   <= |w_level_nxt;
    end
  end

  assign bus.Btn_pulse = r_pulse;
  assign bus.Btn_level = r_level;
  assign bus.Btn_any   = r_any;

endmodule
`default_nettype wire

// File: tb/tb_multi_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_debounce
// Brief    : Scoreboard bench for multi_debounce, with and without auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_debounce;

  localparam int N_CH   = 2;
  localparam int CNT_W  = 4;
  localparam int SETTLE = 4;
  localparam int DELAY  = 8;
  localparam int RATE   = 3;

  logic            CLK     = 1'b0;
  logic            RESET_N = 1'b0;
  logic [N_CH-1:0] btn     = '0;
  int              cyc     = 0;
  int              n_cmp   = 0;
  int              n_err   = 0;

  typedef struct {
    int              cyc;
    logic [N_CH-1:0] v_rep;
    logic [N_CH-1:0] v_norep;
  } exp_t;

  exp_t sb[$];

  multi_debounce_if #(.N_CH(N_CH)) bus_rep ();
  multi_debounce_if #(.N_CH(N_CH)) bus_norep ();

  assign bus_rep.Btn   = btn;
  assign bus_norep.Btn = btn;

  multi_debounce #(
    .N_CH(N_CH), .CNT_W(CNT_W), .SETTLE(SETTLE), .REPEAT_EN(1),
    .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)
  ) u_dut_rep (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus_rep)
  );

  multi_debounce #(
    .N_CH(N_CH), .CNT_W(CNT_W), .SETTLE(SETTLE), .REPEAT_EN(0),
    .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)
  ) u_dut_norep (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus_norep)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] actv, input logic [31:0] expv);
    n_cmp++;
    if (actv !== expv) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, actv, expv);
    end
  endtask

  // Merge a pulse into the entry for cycle t, keeping the queue time-ordered.
  function automatic void sb_push(input int t, input int ch, input bit rep);
    exp_t e;
    int   idx;
    idx = sb.size();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == t) begin
        e = sb[i];
        e.v_rep[ch] = 1'b1;
        if (!rep) e.v_norep[ch] = 1'b1;
        sb[i] = e;
        return;
      end
      if (sb[i].cyc > t) idx = i;
    end
    e.cyc     = t;
    e.v_rep   = '0;
    e.v_norep = '0;
    e.v_rep[ch] = 1'b1;
    if (!rep) e.v_norep[ch] = 1'b1;
    sb.insert(idx, e);
  endfunction

  function automatic void push_reps(input int first, input int last, input int ch);
    for (int t = first; t <= last; t += RATE) sb_push(t, ch, 1'b1);
  endfunction

  // Btn[ch] captured high on edges e0..r: press pulse needs e0..e0+SETTLE high,
  // a pulse at edge t needs the level captured at edge t-2.
  function automatic void push_hold(input int e0, input int r, input int ch);
    int p;
    if (r >= e0 + SETTLE) begin
      p = e0 + SETTLE + 2;
      sb_push(p, ch, 1'b0);
      push_reps(p + DELAY, r + 2, ch);
    end
  endfunction

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic tap(input int ch, input int hold);
    int e0;
    e0 = cyc + 1;
    btn[ch] = 1'b1;
    push_hold(e0, e0 + hold - 1, ch);
    wait_until(e0 + hold - 1);
    btn[ch] = 1'b0;
  endtask

  always begin : mon
    exp_t e;
    @(posedge CLK);
    #1;
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      check("pulse_rep", 32'(bus_rep.Btn_pulse), 32'(e.v_rep));
      check("pulse_norep", 32'(bus_norep.Btn_pulse), 32'(e.v_norep));
    end else begin
      if (bus_rep.Btn_pulse !== '0) check("extra_pulse_rep", 32'(bus_rep.Btn_pulse), 32'd0);
      if (bus_norep.Btn_pulse !== '0) check("extra_pulse_norep", 32'(bus_norep.Btn_pulse), 32'd0);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int e0;
    int r;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_pulse", 32'(bus_rep.Btn_pulse), 32'd0);
    check("rst_level", 32'(bus_rep.Btn_level), 32'd0);
    check("rst_any", 32'(bus_rep.Btn_any), 32'd0);
    check("rst_level_norep", 32'(bus_norep.Btn_level), 32'd0);
    RESET_N = 1'b1;
    wait_until(cyc + 2);

    // Long hold on channel 0: press, repeats, release timing.
    e0 = cyc + 1;
    r  = e0 + 39;
    btn[0] = 1'b1;
    push_hold(e0, r, 0);
    wait_until(e0 + 5);
    check("press_lvl_early", 32'(bus_rep.Btn_level[0]), 32'd0);
    check("press_any_early", 32'(bus_rep.Btn_any), 32'd0);
    wait_until(e0 + 6);
    check("press_lvl", 32'(bus_rep.Btn_level[0]), 32'd1);
    check("press_any", 32'(bus_rep.Btn_any), 32'd1);
    check("press_lvl_norep", 32'(bus_norep.Btn_level[0]), 32'd1);
    wait_until(r);
    btn[0] = 1'b0;
    wait_until(r + 6);
    check("rel_lvl_hold", 32'(bus_rep.Btn_level[0]), 32'd1);
    wait_until(r + 7);
    check("rel_lvl", 32'(bus_rep.Btn_level[0]), 32'd0);
    check("rel_any", 32'(bus_rep.Btn_any), 32'd0);
    wait_until(r + 12);

    // Short highs on channel 1 around the settle boundary.
    e0 = cyc + 1;
    tap(1, 3);
    wait_until(e0 + 6);
    check("glitch3_lvl", 32'(bus_rep.Btn_level[1]), 32'd0);
    wait_until(cyc + 10);
    e0 = cyc + 1;
    tap(1, SETTLE);
    wait_until(e0 + 6);
    check("glitch4_lvl", 32'(bus_rep.Btn_level[1]), 32'd0);
    wait_until(cyc + 10);
    e0 = cyc + 1;
    tap(1, SETTLE + 1);
    wait_until(e0 + 6);
    check("tap5_lvl", 32'(bus_rep.Btn_level[1]), 32'd1);
    wait_until(cyc + 12);

    // Two-cycle low bounce while held, after the first repeat.
    e0 = cyc + 1;
    btn[0] = 1'b1;
    push_hold(e0, e0 + 15, 0);
    wait_until(e0 + 15);
    btn[0] = 1'b0;
    wait_until(e0 + 17);
    btn[0] = 1'b1;
    push_reps(e0 + 20 + RATE, e0 + 32, 0);
    wait_until(e0 + 19);
    check("bounce_lvl", 32'(bus_rep.Btn_level[0]), 32'd1);
    check("bounce_lvl_norep", 32'(bus_norep.Btn_level[0]), 32'd1);
    wait_until(e0 + 30);
    btn[0] = 1'b0;
    wait_until(e0 + 42);

    // Reset in the middle of a hold, button kept pressed through it.
    e0 = cyc + 1;
    btn[0] = 1'b1;
    push_hold(e0, e0 + 7, 0);
    wait_until(e0 + 10);
    #2;
    RESET_N = 1'b0;
    #1;
    check("midrst_pulse", 32'(bus_rep.Btn_pulse), 32'd0);
    check("midrst_lvl", 32'(bus_rep.Btn_level), 32'd0);
    check("midrst_any", 32'(bus_rep.Btn_any), 32'd0);
    check("midrst_lvl_norep", 32'(bus_norep.Btn_level), 32'd0);
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    e0 = cyc + 1;
    push_hold(e0, e0 + 9, 0);
    wait_until(e0 + 5);
    check("postrst_lvl_early", 32'(bus_rep.Btn_level[0]), 32'd0);
    wait_until(e0 + 6);
    check("postrst_lvl", 32'(bus_rep.Btn_level[0]), 32'd1);
    wait_until(e0 + 9);
    btn[0] = 1'b0;
    wait_until(e0 + 20);

    // Both channels pressed on the same edge.
    e0 = cyc + 1;
    btn = 2'b11;
    push_hold(e0, e0 + 7, 0);
    push_hold(e0, e0 + 7, 1);
    wait_until(e0 + 6);
    check("both_lvl", 32'(bus_rep.Btn_level), 32'd3);
    check("both_lvl_norep", 32'(bus_norep.Btn_level), 32'd3);
    wait_until(e0 + 7);
    btn = 2'b00;
    wait_until(e0 + 25);

    check("sb_left", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_debounce.md
MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 The block SHALL have parameter N_CH, default 5: number of independent button channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 14: per-channel counter width.
REQ-003 The block SHALL have parameter SETTLE, default 6100: stable cycles required to accept a press or release (2..2^CNT_W-1).
REQ-004 The block SHALL have parameter REPEAT_EN, default 1: 1 enables auto-repeat pulses while held.
REQ-005 The block SHALL have parameter REPEAT_DELAY, default 12200: cycles from press pulse to first repeat pulse (2..2^CNT_W-1).
REQ-006 The block SHALL have parameter REPEAT_RATE, default 2440: cycles between subsequent repeat pulses (2..2^CNT_W-1).
REQ-007 The block SHALL have port CLK  input  1  single clock, about 24.4 kHz.
REQ-008 The block SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-009 The block SHALL have port Btn  input  N_CH  raw asynchronous button levels, active-high.
REQ-010 The block SHALL have port Btn_pulse  output  N_CH  one-cycle pulse per accepted press and per repeat.
REQ-011 The block SHALL have port Btn_level  output  N_CH  debounced held level.
REQ-012 The block SHALL have port Btn_any  output  1  OR of Btn_level.

Function
REQ-013 Each Btn bit SHALL pass through a 2-flop synchronizer; the second stage is s_btn[i]; channels share no state.
REQ-014 Each channel SHALL run a 4-state FSM: IDLE, PRESS_WAIT, HELD, REL_WAIT, with a CNT_W-bit counter cnt and a 1-bit flag rpt.
REQ-015 In IDLE: cnt<=0, rpt<=0; s_btn=1 -> PRESS_WAIT.
REQ-016 In PRESS_WAIT: s_btn=0 -> IDLE, cnt<=0; else cnt==SETTLE-1 -> HELD, cnt<=0, Btn_pulse=1 for one cycle, Btn_level<=1; else cnt<=cnt+1.
REQ-017 In HELD: s_btn=0 -> REL_WAIT, cnt<=0; else REPEAT_EN=1 and cnt==(rpt ? REPEAT_RATE : REPEAT_DELAY)-1 -> Btn_pulse=1 for one cycle, cnt<=0, rpt<=1; else cnt<=cnt+1.
REQ-018 With REPEAT_EN=0, cnt in HELD SHALL hold at 0 and no repeat pulse SHALL occur.
REQ-019 In REL_WAIT: s_btn=1 -> HELD, cnt<=0, rpt kept; else cnt==SETTLE-1 -> IDLE, Btn_level<=0; else cnt<=cnt+1.
REQ-020 The FSM SHALL make exactly one transition per cycle and SHALL ignore every other condition in that cycle.
REQ-021 Press latency: if Btn is first captured high at edge 0 and held, Btn_pulse SHALL go high after edge SETTLE+2 and low after edge SETTLE+3.
REQ-022 Repeat timing: for a press pulse after edge P, repeat pulses SHALL follow edges P+REPEAT_DELAY, then each further REPEAT_RATE edges.
REQ-023 A low glitch shorter than SETTLE during HELD SHALL NOT drop Btn_level or create a press pulse, and SHALL restart the repeat interval.
REQ-024 A high glitch shorter than SETTLE in IDLE/PRESS_WAIT SHALL produce no pulse and no level change.
REQ-025 cnt SHALL never wrap, because every compare terminates before 2^CNT_W-1.
REQ-026 Btn_pulse, Btn_level and Btn_any SHALL be registered; Btn_any SHALL be the registered OR of next-state Btn_level, so it is coincident with Btn_level.
REQ-027 Simultaneous presses on several channels SHALL produce simultaneous, independent pulses.

Reset
REQ-028 RESET_N=0 SHALL asynchronously force all FSMs to IDLE, cnt=0, rpt=0, synchronizer flops=0, Btn_pulse=0, Btn_level=0, Btn_any=0.
REQ-029 A reset asserted mid-press or mid-hold SHALL discard the event; after release, a still-held button SHALL need a full SETTLE again and SHALL yield a new press pulse.

Verification (N_CH=2, SETTLE=4, REPEAT_DELAY=8, REPEAT_RATE=3)
REQ-030 Btn[0] 0->1 captured at edge 0, held -> Btn_pulse[0]=1 only after edge 6; Btn_level[0]=1 from edge 6; Btn_any=1 from edge 6.
REQ-031 Btn[0] held 30 cycles after pulse at edge 6 -> further pulses after edges 14, 17, 20, ...; REPEAT_EN=0 -> no further pulses.
REQ-032 Btn[1] high 3 cycles then low -> no Btn_pulse[1]; Btn_level[1] stays 0.
REQ-033 Held Btn[0] drops for 2 cycles -> Btn_level[0] stays 1, no press pulse; next repeat comes REPEAT_RATE cycles after re-entering HELD.
REQ-034 RESET_N pulsed low while Btn[0] is held in HELD -> all outputs 0 immediately; after release, a new pulse comes SETTLE+2 edges later.
REQ-035 Both channels pressed on the same edge -> Btn_pulse=2'b11 in the same cycle.
